// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared opcodes, DDRAM address map, responder state and address-counter helpers.
`timescale 1ns/1ps
package lcd_pkg;

    // Instruction opcodes; an instruction is identified by its highest set bit.
    localparam logic [7:0] OP_CLR   = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // DDRAM address map: two-line uses 0x00-0x27 and 0x40-0x67, one-line uses 0x00-0x4F.
    localparam logic [6:0] LINE0_BASE   = 7'h00;
    localparam logic [6:0] LINE1_BASE   = 7'h40;
    localparam logic [6:0] LINE0_END    = 7'h27;
    localparam logic [6:0] LINE1_END    = 7'h67;
    localparam logic [6:0] ONE_LINE_END = 7'h4F;

    // Both modes have 80 visible cells; the fill index counts 0..79.
    localparam logic [6:0] FILL_LAST = 7'd79;

    typedef enum logic [1:0] {
        ST_INIT_FILL  = 2'd0,
        ST_IDLE       = 2'd1,
        ST_BUSY       = 2'd2,
        ST_CLEAR_FILL = 2'd3
    } lcd_state_e;

    // Internal state made visible for checkers: FSM state, I/D and the stored S flag.
    typedef struct packed {
        lcd_state_e state;
        logic       inc;
        logic       shift_en;
    } lcd_dbg_t;

    // True when addr is a visible DDRAM cell in the given display mode.
    function automatic logic addr_valid(input logic [6:0] addr, input logic two);
        if (two) begin
            return (addr <= LINE0_END) || ((addr >= LINE1_BASE) && (addr <= LINE1_END));
        end
        return addr <= ONE_LINE_END;
    endfunction

    // One step of the address counter with the line wrap rules of each mode.
    function automatic logic [6:0] ac_step(input logic [6:0] addr, input logic inc,
                                           input logic two);
        logic [6:0] nxt;
        if (inc) begin
            if (two && addr == LINE0_END)          nxt = LINE1_BASE;
            else if (two && addr == LINE1_END)     nxt = LINE0_BASE;
            else if (!two && addr == ONE_LINE_END) nxt = LINE0_BASE;
            else                                   nxt = addr + 7'd1;
        end else begin
            if (two && addr == LINE0_BASE)         nxt = LINE1_END;
            else if (two && addr == LINE1_BASE)    nxt = LINE0_END;
            else if (!two && addr == LINE0_BASE)   nxt = ONE_LINE_END;
            else                                   nxt = addr - 7'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_hd44780_responder_ddram.sv
// 128x8 display RAM: one synchronous write port, a combinational bus read port
// and a registered side read port that returns pre-write data on a collision.
`timescale 1ns/1ps
module lcd_ddram (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] baddr,
    output logic [7:0] bdata,
    input  logic [6:0] saddr,
    output logic [7:0] sdata
);

    logic [7:0] mem [128];
    logic [7:0] sdata_q;
    logic [7:0] sdata_d;

    // Storage write port; contents are not reset, the init fill covers visible cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Side read sees the array before this cycle's write lands.
    always_comb begin
        sdata_d = mem[saddr];
    end

    // Side read data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sdata_q <= 8'h00;
        end else begin
            sdata_q <= sdata_d;
        end
    end

    assign bdata = mem[baddr];
    assign sdata = sdata_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-style controller model: decodes bus transactions on the EN falling
// edge, runs the instruction subset, keeps the DDRAM image and the busy timer.
//
// Bus handshake: the driver holds EN high for at least two cycles with RS/RW/data
// stable; the transaction is taken on the cycle EN is first seen low, using the
// RS/RW/data captured in the last cycle EN was high. Reads drive lcd_data_out
// with lcd_data_oe from one cycle after EN rises until one cycle after it falls.
`timescale 1ns/1ps
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES = 2000,
    parameter int LONG_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic [6:0] ac_out,
    output logic       display_on,
    output logic       two_line,
    output logic       cmd_strobe,
    output logic       proto_err,
    output lcd_dbg_t   dbg
);

    localparam int MAX_CYCLES = (LONG_CYCLES > BUSY_CYCLES) ? LONG_CYCLES : BUSY_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LOAD = CW'(LONG_CYCLES - 1);

    lcd_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    fill_cnt_q, fill_cnt_d;
    logic [6:0]    fill_addr_q, fill_addr_d;
    logic [6:0]    ac_q, ac_d;
    logic          id_q, id_d;
    logic          sh_q, sh_d;
    logic          disp_q, disp_d;
    logic          two_q, two_d;
    logic          strobe_q, strobe_d;
    logic          perr_q, perr_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic          rw_q, rw_d;
    logic [7:0]    dat_q, dat_d;
    logic [7:0]    dout_q, dout_d;
    logic          oe_q, oe_d;

    logic          mem_we;
    logic [6:0]    mem_waddr;
    logic [7:0]    mem_wdata;
    logic [7:0]    bus_rdata;

    logic          fall;
    logic          accept;
    logic          go_long;
    logic          go_clear;

    lcd_ddram u_ddram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .baddr (ac_q),
        .bdata (bus_rdata),
        .saddr (rd_addr),
        .sdata (rd_char)
    );

    assign busy = (state_q != ST_IDLE);

    // Bus capture, background fill/busy sequencing and transaction decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_cnt_d  = fill_cnt_q;
        fill_addr_d = fill_addr_q;
        ac_d        = ac_q;
        id_d        = id_q;
        sh_d        = sh_q;
        disp_d      = disp_q;
        two_d       = two_q;
        strobe_d    = 1'b0;
        perr_d      = 1'b0;
        en_d        = lcd_en;
        rs_d        = rs_q;
        rw_d        = rw_q;
        dat_d       = dat_q;
        oe_d        = lcd_en & lcd_rw;
        dout_d      = 8'h00;
        mem_we      = 1'b0;
        mem_waddr   = ac_q;
        mem_wdata   = dat_q;
        fall        = en_q & ~lcd_en;
        accept      = 1'b0;
        go_long     = 1'b0;
        go_clear    = 1'b0;

        if (lcd_en) begin
            rs_d  = lcd_rs;
            rw_d  = lcd_rw;
            dat_d = lcd_data_in;
        end
        if (lcd_en && lcd_rw) begin
            dout_d = lcd_rs ? bus_rdata : {busy, ac_q};
        end

        case (state_q)
            ST_INIT_FILL, ST_CLEAR_FILL: begin
                mem_we      = 1'b1;
                mem_waddr   = fill_addr_q;
                mem_wdata   = ASCII_SPACE;
                fill_addr_d = ac_step(fill_addr_q, 1'b1, two_q);
                fill_cnt_d  = fill_cnt_q + 7'd1;
                if (state_q == ST_CLEAR_FILL) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (fill_cnt_q == FILL_LAST) begin
                    if (state_q == ST_INIT_FILL || cnt_q == '0) state_d = ST_IDLE;
                    else                                         state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (fall) begin
            if (rw_q && !rs_q) begin
                // Status read: observation only.
            end else if (busy) begin
                perr_d = 1'b1;
            end else if (rw_q) begin
                ac_d   = ac_step(ac_q, id_q, two_q);
                accept = 1'b1;
            end else if (rs_q) begin
                mem_we    = 1'b1;
                mem_waddr = ac_q;
                mem_wdata = dat_q;
                ac_d      = ac_step(ac_q, id_q, two_q);
                accept    = 1'b1;
            end else if (dat_q >= OP_DDRAM) begin
                if (addr_valid(dat_q[6:0], two_q)) begin
                    ac_d   = dat_q[6:0];
                    accept = 1'b1;
                end else begin
                    perr_d = 1'b1;
                end
            end else if (dat_q >= OP_CGRAM) begin
                accept = 1'b1;
            end else if (dat_q >= OP_FUNC) begin
                two_d  = dat_q[3];
                accept = 1'b1;
            end else if (dat_q >= OP_SHIFT) begin
                if (!dat_q[3]) begin
                    ac_d = ac_step(ac_q, dat_q[2], two_q);
                end
                accept = 1'b1;
            end else if (dat_q >= OP_DISP) begin
                disp_d = dat_q[2];
                accept = 1'b1;
            end else if (dat_q >= OP_ENTRY) begin
                id_d   = dat_q[1];
                sh_d   = dat_q[0];
                accept = 1'b1;
            end else if (dat_q >= OP_HOME) begin
                ac_d    = LINE0_BASE;
                accept  = 1'b1;
                go_long = 1'b1;
            end else if (dat_q == OP_CLR) begin
                ac_d     = LINE0_BASE;
                id_d     = 1'b1;
                accept   = 1'b1;
                go_clear = 1'b1;
            end else begin
                // 0x00 is not an instruction.
                perr_d = 1'b1;
            end
        end

        if (accept) begin
            strobe_d = 1'b1;
            state_d  = ST_BUSY;
            cnt_d    = go_long ? LONG_LOAD : BUSY_LOAD;
            if (go_clear) begin
                state_d     = ST_CLEAR_FILL;
                cnt_d       = LONG_LOAD;
                fill_cnt_d  = 7'd0;
                fill_addr_d = LINE0_BASE;
            end
        end
    end

    // State and register update; reset aborts any busy or fill and restarts the init fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT_FILL;
            cnt_q       <= '0;
            fill_cnt_q  <= 7'd0;
            fill_addr_q <= LINE0_BASE;
            ac_q        <= 7'd0;
            id_q        <= 1'b1;
            sh_q        <= 1'b0;
            disp_q      <= 1'b0;
            two_q       <= 1'b0;
            strobe_q    <= 1'b0;
            perr_q      <= 1'b0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            dat_q       <= 8'h00;
            dout_q      <= 8'h00;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_addr_q <= fill_addr_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            sh_q        <= sh_d;
            disp_q      <= disp_d;
            two_q       <= two_d;
            strobe_q    <= strobe_d;
            perr_q      <= perr_d;
            en_q        <= en_d;
            rs_q        <= rs_d;
            rw_q        <= rw_d;
            dat_q       <= dat_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
        end
    end

    assign lcd_data_out = dout_q;
    assign lcd_data_oe  = oe_q;
    assign ac_out       = ac_q;
    assign display_on   = disp_q;
    assign two_line     = two_q;
    assign cmd_strobe   = strobe_q;
    assign proto_err    = perr_q;
    assign dbg          = '{state: state_q, inc: id_q, shift_en: sh_q};

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder: directed bus sequences plus randomized
// instruction/data traffic checked against a linear-position DDRAM model.
`timescale 1ns/1ps
module tb_lcd_hd44780_responder;
    import lcd_pkg::*;

    localparam int BUSY_CYC = 20;
    localparam int LONG_CYC = 100;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_en = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [7:0] rd_char;
    logic       busy;
    logic [6:0] ac_out;
    logic       display_on;
    logic       two_line;
    logic       cmd_strobe;
    logic       proto_err;
    lcd_dbg_t   dbg;

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    lcd_hd44780_responder #(
        .BUSY_CYCLES (BUSY_CYC),
        .LONG_CYCLES (LONG_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_en       (lcd_en),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char),
        .busy         (busy),
        .ac_out       (ac_out),
        .display_on   (display_on),
        .two_line     (two_line),
        .cmd_strobe   (cmd_strobe),
        .proto_err    (proto_err),
        .dbg          (dbg)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_q[$];
    logic [6:0] addr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Cells are addressed as a linear display position 0..79 (line*40+col in
    // two-line mode), so counter wrap is a plain modulo-80 step.
    logic [7:0] m_mem[128];
    bit         m_kn[128];
    logic [6:0] m_ac;
    bit         m_id, m_sh, m_two, m_disp;

    function automatic bit m_valid(input logic [6:0] a, input bit two);
        int v = int'(a);
        if (two) return (v < 40) || (v >= 64 && v < 104);
        return v < 80;
    endfunction

    function automatic int m_lin(input logic [6:0] a, input bit two);
        if (two && int'(a) >= 64) return int'(a) - 64 + 40;
        return int'(a);
    endfunction

    function automatic logic [6:0] m_unlin(input int i, input bit two);
        if (two && i >= 40) return 7'(i - 40 + 64);
        return 7'(i);
    endfunction

    function automatic logic [6:0] m_next(input logic [6:0] a, input bit inc, input bit two);
        return m_unlin((m_lin(a, two) + (inc ? 1 : 79)) % 80, two);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_kn[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            m_mem[i] = 8'h20;
            m_kn[i]  = 1'b1;
        end
        m_ac = 7'd0; m_id = 1'b1; m_sh = 1'b0; m_two = 1'b0; m_disp = 1'b0;
    endtask

    // Applies a write from an idle responder; reports acceptance and busy length.
    task automatic model_write(input bit rs, input logic [7:0] d, output bit ok, output int blen);
        ok = 1'b1;
        blen = BUSY_CYC;
        if (rs) begin
            m_mem[m_ac] = d;
            m_kn[m_ac]  = 1'b1;
            m_ac        = m_next(m_ac, m_id, m_two);
        end else if (d >= 8'h80) begin
            if (m_valid(d[6:0], m_two)) m_ac = d[6:0];
            else ok = 1'b0;
        end else if (d >= 8'h40) begin
        end else if (d >= 8'h20) begin
            m_two = d[3];
        end else if (d >= 8'h10) begin
            if (!d[3]) m_ac = m_next(m_ac, d[2], m_two);
        end else if (d >= 8'h08) begin
            m_disp = d[2];
        end else if (d >= 8'h04) begin
            m_id = d[1];
            m_sh = d[0];
        end else if (d >= 8'h02) begin
            m_ac = 7'd0;
            blen = LONG_CYC;
        end else if (d == 8'h01) begin
            for (int p = 0; p < 80; p++) begin
                m_mem[m_unlin(p, m_two)] = 8'h20;
                m_kn[m_unlin(p, m_two)]  = 1'b1;
            end
            m_ac = 7'd0;
            m_id = 1'b1;
            blen = LONG_CYC;
        end else begin
            ok = 1'b0;
        end
        if (!ok) blen = 0;
    endtask

    // ---------------- driver tasks (start and end on a falling clock edge) ----------------
    task automatic bus_write(input bit rs, input logic [7:0] d, input bit exp_ok);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lcd_en = 1'b0;
        @(negedge clk);
        check("wr_strobe", cmd_strobe, exp_ok);
        check("wr_proto_err", proto_err, !exp_ok);
    endtask

    task automatic bus_read(input bit rs, input bit exp_strobe, input bit exp_perr,
                            output logic [7:0] v);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
        @(negedge clk);
        check("rd_oe_high", lcd_data_oe, 1'b1);
        v = lcd_data_out;
        @(negedge clk);
        lcd_en = 1'b0;
        @(negedge clk);
        check("rd_oe_low", lcd_data_oe, 1'b0);
        check("rd_dout_low", lcd_data_out, 8'h00);
        check("rd_strobe", cmd_strobe, exp_strobe);
        check("rd_proto_err", proto_err, exp_perr);
        lcd_rw = 1'b0;
    endtask

    task automatic measure_busy(input int exp_len);
        int n = 0;
        while (busy && n < LONG_CYC + 20) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, exp_len);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < LONG_CYC + 20) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic do_write(input bit rs, input logic [7:0] d);
        bit ok;
        int blen;
        model_write(rs, d, ok, blen);
        bus_write(rs, d, ok);
        measure_busy(blen);
        check("ac_out", ac_out, m_ac);
    endtask

    task automatic do_read(input bit rs);
        logic [7:0] v;
        logic [7:0] exp_v;
        bit         kn;
        logic [6:0] ac0 = m_ac;
        exp_v = m_mem[m_ac];
        kn    = m_kn[m_ac];
        if (rs) m_ac = m_next(m_ac, m_id, m_two);
        bus_read(rs, rs, 1'b0, v);
        if (rs && kn) check("rd_data", v, exp_v);
        if (!rs) check("rd_status", v, {1'b0, ac0});
        measure_busy(rs ? BUSY_CYC : 0);
        check("ac_out", ac_out, m_ac);
    endtask

    task automatic side_read(input logic [6:0] a, output logic [7:0] v);
        rd_addr = a;
        @(negedge clk);
        v = rd_char;
    endtask

    // Compares every known visible cell of the current mode through the side port.
    task automatic dump_ddram(input string tag);
        logic [7:0] v;
        logic [6:0] a;
        for (int i = 0; i < 128; i++) begin
            if (m_kn[i] && m_valid(7'(i), m_two)) begin
                exp_q.push_back(m_mem[i]);
                addr_q.push_back(7'(i));
            end
        end
        while (exp_q.size() > 0) begin
            a = addr_q.pop_front();
            side_read(a, v);
            check($sformatf("%s[%02h]", tag, a), v, exp_q.pop_front());
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] v;
        bit         ok;
        int         blen;
        int         n;
        int         op;
        logic [6:0] a;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b1);
        check("rst_dout", lcd_data_out, 8'h00);
        check("rst_oe", lcd_data_oe, 1'b0);
        check("rst_rd_char", rd_char, 8'h00);
        check("rst_ac", ac_out, 7'h00);
        check("rst_display_on", display_on, 1'b0);
        check("rst_two_line", two_line, 1'b0);
        check("rst_strobe", cmd_strobe, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_inc", dbg.inc, 1'b1);

        rst = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("init_busy_len", n, 80);
        dump_ddram("init_cell");

        // Two-line mode, address 0, two characters.
        do_write(1'b0, 8'h38);
        check("two_line_set", two_line, 1'b1);
        do_write(1'b0, 8'h80);
        do_write(1'b1, 8'h2D);
        do_write(1'b1, 8'h31);
        check("ac_after_two_chars", ac_out, 7'h02);
        side_read(7'h00, v); check("cell_00", v, 8'h2D);
        side_read(7'h01, v); check("cell_01", v, 8'h31);

        // End of line 0 wraps to start of line 1.
        do_write(1'b0, 8'h38);
        do_write(1'b0, 8'hA7);
        do_write(1'b1, 8'h41);
        check("ac_wrap_27_40", ac_out, 7'h40);
        side_read(7'h27, v); check("cell_27", v, 8'h41);

        // Address 0x30 is a gap in two-line mode.
        do_write(1'b0, 8'hB0);
        check("ac_after_bad_addr", ac_out, 7'h40);

        // Write while busy is dropped; status read shows busy.
        model_write(1'b1, 8'h42, ok, blen);
        bus_write(1'b1, 8'h42, ok);
        bus_write(1'b1, 8'h43, 1'b0);
        check("ac_after_busy_write", ac_out, m_ac);
        bus_read(1'b0, 1'b0, 1'b0, v);
        check("status_busy_bit", v[7], 1'b1);
        check("status_busy_ac", v[6:0], m_ac);
        wait_idle();
        side_read(m_ac, v); check("cell_not_overwritten", v, m_mem[m_ac]);

        // Randomized traffic from a freshly cleared two-line display.
        do_write(1'b0, 8'h01);
        for (int it = 0; it < 70; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: do_write(1'b1, 8'($urandom_range(33, 126)));
                4: begin
                    if ($urandom_range(0, 1) == 1) a = m_unlin($urandom_range(0, 79), m_two);
                    else a = 7'($urandom_range(0, 127));
                    do_write(1'b0, {1'b1, a});
                end
                5: begin
                    do_write(1'b0, 8'h04 | 8'($urandom_range(0, 3)));
                    check("entry_inc", dbg.inc, m_id);
                    check("entry_shift", dbg.shift_en, m_sh);
                end
                6: do_write(1'b0, 8'h10 | 8'($urandom_range(0, 1) << 2) | 8'($urandom_range(0, 1) << 3));
                7: do_read(1'b1);
                8: do_read(1'b0);
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        do_write(1'b0, 8'h02);
                    end else begin
                        do_write(1'b0, 8'h08 | 8'($urandom_range(0, 7)));
                        check("display_on", display_on, m_disp);
                    end
                end
            endcase
        end
        dump_ddram("rand_cell");

        // Reset in the middle of a clear fill restarts the init fill.
        model_write(1'b0, 8'h01, ok, blen);
        bus_write(1'b0, 8'h01, ok);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midclr_rst_busy", busy, 1'b1);
        check("midclr_rst_two_line", two_line, 1'b0);
        rst = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midclr_busy_len", n, 80);
        model_reset();
        check("midclr_ac", ac_out, m_ac);
        dump_ddram("refill_cell");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
